uart_message_sequencer: RTL

UART_MESSAGE_SEQUENCER -- requirements
Module: uart_message_sequencer

---
 rtl/uart_message_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_message_sequencer.sv
// uart_message_sequencer
// Streams a constant MESSAGE, one byte per handshake, to a downstream UART
// transmitter. A start in IDLE sends REPEAT_COUNT copies (0 = until abort),
// separated by GAP_CYCLES idle cycles, then pulses done for one cycle.
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous reset, active high (asserted = 1)
//   start      begin a run (sampled only in IDLE)
//   abort      synchronous cancel, priority over start
//   tx_ready   downstream can accept a byte
//   tx_valid   tx_data holds a valid byte
//   tx_data    byte being offered
//   busy       high in any state other than IDLE
//   done       one-cycle pulse when a finite run completes
//   byte_index index of the byte being offered
//   msg_count  messages fully sent in the current run
module uart_message_sequencer #(
   parameter int unsigned          MSG_LEN      = 3,
   parameter logic [MSG_LEN*8-1:0] MESSAGE      = "ABC",
   parameter logic [15:0]          REPEAT_COUNT = 16'd1,
   parameter logic [15:0]          GAP_CYCLES   = 16'd0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic        abort,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic        done,
   output logic [5:0]  byte_index,
   output logic [15:0] msg_count
);

   localparam int unsigned IDX_W = 6;
   localparam int unsigned CNT_W = 16;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
   // Gap counter counts down to zero, so GAP_CYCLES cycles need a load of GAP_CYCLES-1.
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 16'd1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   gap_cnt_q;
   logic [CNT_W-1:0]   gap_cnt_d;
   logic               tx_valid_d;
   logic [7:0]         tx_data_d;
   logic               busy_d;
   logic               done_d;
   logic [IDX_W-1:0]   byte_index_d;
   logic [CNT_W-1:0]   msg_count_d;

   logic               xfer_c;
   logic               last_c;
   logic [CNT_W-1:0]   cnt_inc_c;
   logic               hit_c;

   // Byte idx of MESSAGE; byte 0 is the most significant byte (first character).
   function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] idx);
      logic [7:0] b;
      b = 8'h00;
      for (int unsigned i = 0; i < MSG_LEN; i++) begin
         if (idx == IDX_W'(i)) begin
            b = MESSAGE[(MSG_LEN - 1 - i) * 8 +: 8];
         end
      end
      return b;
   endfunction

   // Handshake and end-of-run qualifiers.
   always_comb begin
      xfer_c    = tx_valid & tx_ready;
      last_c    = (byte_index == LAST_IDX);
      cnt_inc_c = msg_count + 16'd1;
      hit_c     = (REPEAT_COUNT != 16'd0) && (cnt_inc_c == REPEAT_COUNT);
   end

   // State register.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (xfer_c && last_c) begin
               if (hit_c) begin
                  state_d = ST_DONE;
               end else if (GAP_CYCLES == 16'd0) begin
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (gap_cnt_q == 16'd0) begin
               state_d = ST_SEND;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output / datapath next values; everything holds unless a case updates it.
   always_comb begin
      tx_valid_d   = (state_d == ST_SEND);
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
      tx_data_d    = tx_data;
      byte_index_d = byte_index;
      msg_count_d  = msg_count;
      gap_cnt_d    = gap_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (state_d == ST_SEND) begin
               byte_index_d = 6'd0;
               msg_count_d  = 16'd0;
               tx_data_d    = msg_byte(6'd0);
            end
         end
         ST_SEND: begin
            if (xfer_c) begin
               if (last_c) begin
                  msg_count_d  = cnt_inc_c;
                  byte_index_d = 6'd0;
                  if (state_d == ST_GAP) begin
                     gap_cnt_d = GAP_LOAD;
                  end
               end else begin
                  byte_index_d = byte_index + 6'd1;
               end
               // Only present a new byte if still offering; otherwise tx_data holds.
               if (state_d == ST_SEND) begin
                  tx_data_d = msg_byte(byte_index_d);
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q != 16'd0) begin
               gap_cnt_d = gap_cnt_q - 16'd1;
            end else if (state_d == ST_SEND) begin
               byte_index_d = 6'd0;
               tx_data_d    = msg_byte(6'd0);
            end
         end
         default: begin
         end
      endcase
   end

   // Registered outputs and counters.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         tx_valid   <= 1'b0;
         tx_data    <= 8'h00;
         busy       <= 1'b0;
         done       <= 1'b0;
         byte_index <= 6'd0;
         msg_count  <= 16'd0;
         gap_cnt_q  <= 16'd0;
      end else begin
         tx_valid   <= tx_valid_d;
         tx_data    <= tx_data_d;
         busy       <= busy_d;
         done       <= done_d;
         byte_index <= byte_index_d;
         msg_count  <= msg_count_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

endmodule
